smaesh_stream_sequencer: RTL
============================

# smaesh_stream_sequencer

Host-side driver for the SMAesH core input streams. Accepts a single tagged command stream, splits it into the seed, key and data valid/ready streams consumed by the core's input arbitration, and keeps exactly one stream active at a time so that no transaction can be reordered by the core's seed > key > data precedence. It also rejects illegally ordered traffic and counts completed transactions.

## Interface

Parameters:
- `d`, default 2: number of shares; share-word width is 32*d.
- `SEED_W`, default 80: PRNG seed width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command beat valid.
- `cmd_ready`  out  1  command beat accepted.
- `cmd_op`  in  2  opcode, sampled on the first beat only: 0 SEED, 1 KEY, 2 DATA, 3 reserved.
- `cmd_key_size`  in  2  sampled on the first KEY beat: 0 AES-128, 1 AES-192, 2 AES-256, 3 illegal.
- `cmd_seed`  in  SEED_W  seed payload.
- `cmd_word`  in  32*d  shared key/data word.
- `seed_valid`, `seed_ready`  out/in  1  seed stream handshake; `seed` out SEED_W.
- `key_valid`, `key_ready`  out/in  1  key stream handshake; `key_word` out 32*d; `key_size` out 2.
- `data_valid`, `data_ready`  out/in  1  data stream handshake; `data_word` out 32*d.
- `err_clear`  in  1  clears sticky errors.
- `err_op`  out  1  sticky: reserved opcode or illegal key size received.
- `err_order`  out  1  sticky: DATA received before a completed SEED and KEY.
- `blk_count`  out  16  completed DATA transactions, wraps 0xFFFF -> 0.

## Operation

- FSM states: IDLE, SEED, KEY, DATA, DROP.
- IDLE: first beat with `cmd_valid` decodes `cmd_op`.
  - SEED: transaction length 1 beat.
  - KEY: length 4/6/8 beats for size 0/1/2.
  - DATA: length 4 beats.
  - Op 3 or key size 3: beat consumed, `err_op` set, stays IDLE.
  - DATA while `seeded`==0 or `keyed`==0: enter DROP for 4 beats (consumed, not forwarded), set `err_order`.
- During SEED/KEY/DATA/DROP, `cmd_op` and `cmd_key_size` are ignored. A beat counter counts accepted beats. Return to IDLE when the last beat completes its downstream handshake; DROP returns to IDLE after the last beat is accepted.
- Single output buffer per active stream. Payload and valid are registered on `cmd_valid & cmd_ready`.
- `cmd_ready = ~buf_valid | target_ready` in forwarding states, 1 in DROP and IDLE-error cases. Full throughput: one beat per cycle when the target stays ready.
- Once asserted, valid and payload stay stable until the ready handshake.
- Only the active stream's valid may be high; the other valids are 0.
- `seeded` is set after the seed handshake. `keyed` is set after the last key beat handshake. Neither is cleared except by `rst`.
- `key_size` is held from the first key beat for the whole transaction.
- `blk_count` increments on the last data-beat handshake.
- `err_clear` clears both sticky errors. If a new error occurs in the same cycle as `err_clear`, the error wins.

## Timing

- Reset values: all valids 0, `cmd_ready` 0 during `rst`, payload outputs 0, errors 0, `blk_count` 0, FSM IDLE, `seeded`/`keyed` 0.
- Latency: a command beat accepted at cycle t has its valid asserted at t+1.
- Back-to-back transactions: the next transaction's first beat can be accepted in the cycle the previous last beat completes its handshake. The new valid then rises at the next cycle.
- Downstream ready low: the buffer holds; `cmd_ready` drops; no beat is lost or duplicated.
- `rst` mid-transaction: the transaction is abandoned, all state returns to reset values next cycle, and partial beats are not completed.

## Structure

- Shared package `smaesh_seq_pkg`:
  - opcode constants SEED/KEY/DATA/RSVD;
  - FSM state encoding;
  - beat-count function `key_beats(size)`;
  - DATA_BEATS = 4.
- One natural sub-module: `smaesh_seq_obuf`, a single-entry valid/ready register slice parameterised by width, instantiated once per stream.

## Test plan

- **Reset then SEED:** seed 0x1234…ABCD, `seed_ready` held low 3 cycles -> `seed_valid` high from t+1 with stable payload; handshake completes on the cycle ready rises; `seeded`=1.
- **SEED, then KEY size 0 with words W0..W3, `key_ready`=1:** four consecutive `key_valid` cycles; `key_size`=0 throughout; no `data_valid`; `keyed`=1.
- **SEED, KEY-256 (8 beats), 3×DATA with `data_ready` toggling 1/0:** every word forwarded once, in order; `blk_count`=3.
- **DATA right after reset:** 4 beats consumed, `data_valid` never asserted, `err_order`=1; `err_clear` -> 0.
- **Op 3, then KEY size 3:** each single beat is dropped and `err_op`=1; a subsequent valid SEED still works.
- **Mid-KEY `rst`, and `blk_count` wrap:** assert `rst` at beat 2 of a KEY -> all outputs 0 next cycle. Preload 0xFFFF completed blocks, then one more DATA -> `blk_count`=0.

Source files
------------

// File: rtl/smaesh_seq_pkg.sv
// Shared opcodes, FSM encoding and transaction-length helpers for the SMAesH stream sequencer.
package smaesh_seq_pkg;

    localparam logic [1:0] OP_SEED = 2'd0;
    localparam logic [1:0] OP_KEY  = 2'd1;
    localparam logic [1:0] OP_DATA = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    localparam logic [1:0] KS_ILLEGAL = 2'd3;
    localparam logic [3:0] DATA_BEATS = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_KEY,
        ST_DATA,
        ST_DROP
    } state_e;

    function automatic logic [3:0] key_beats(input logic [1:0] size);
        case (size)
            2'd0:    key_beats = 4'd4;
            2'd1:    key_beats = 4'd6;
            2'd2:    key_beats = 4'd8;
            default: key_beats = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/smaesh_stream_sequencer_if.sv
// Command stream plus the seed/key/data streams and status of the SMAesH input sequencer.
interface smaesh_stream_sequencer_if #(
    parameter int d      = 2,
    parameter int SEED_W = 80
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [1:0]        cmd_key_size;
    logic [SEED_W-1:0] cmd_seed;
    logic [32*d-1:0]   cmd_word;

    logic              seed_valid;
    logic              seed_ready;
    logic [SEED_W-1:0] seed;

    logic              key_valid;
    logic              key_ready;
    logic [32*d-1:0]   key_word;
    logic [1:0]        key_size;

    logic              data_valid;
    logic              data_ready;
    logic [32*d-1:0]   data_word;

    logic              err_clear;
    logic              err_op;
    logic              err_order;
    logic [15:0]       blk_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_key_size, cmd_seed, cmd_word,
        output cmd_ready,
        output seed_valid, seed, input seed_ready,
        output key_valid, key_word, key_size, input key_ready,
        output data_valid, data_word, input data_ready,
        input  err_clear,
        output err_op, err_order, blk_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_key_size, cmd_seed, cmd_word,
        input  cmd_ready,
        input  seed_valid, seed, output seed_ready,
        input  key_valid, key_word, key_size, output key_ready,
        input  data_valid, data_word, output data_ready,
        output err_clear,
        input  err_op, err_order, blk_count
    );

endinterface

// File: rtl/smaesh_seq_obuf.sv
// Single-entry valid/ready register slice; load lands the payload one cycle later.
// A load in the same cycle as the draining handshake wins, so back-to-back beats never bubble.
module smaesh_seq_obuf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] payload,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= payload;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/smaesh_stream_sequencer.sv
// Splits one tagged command stream into the SMAesH seed/key/data streams, one stream active at a time.
// Beat accepted at t is valid at t+1; cmd_ready follows the active buffer's ready (no loss, no duplication).
module smaesh_stream_sequencer
    import smaesh_seq_pkg::*;
#(
    parameter int d      = 2,
    parameter int SEED_W = 80
) (
    input  logic                       clk,
    input  logic                       rst,
    smaesh_stream_sequencer_if.slave   bus
);

    localparam int WW = 32 * d;

    state_e      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [3:0]  len, len_n;
    logic [1:0]  ks_q, ks_n;
    logic        seeded, keyed, seeded_eff, keyed_eff;
    logic        err_op_q, err_order_q, set_err_op, set_err_order;
    logic [15:0] blk_count_q;

    logic        fwd, free, done_in, out_vld, out_rdy, out_hs, last_hs;
    logic        cmd_ready, acc, dec_bad_op, dec_order, blk_inc;
    logic        seed_load, key_load, data_load;

    always_comb begin
        out_vld = 1'b0;
        out_rdy = 1'b0;
        case (state)
            ST_SEED: begin out_vld = bus.seed_valid; out_rdy = bus.seed_ready; end
            ST_KEY:  begin out_vld = bus.key_valid;  out_rdy = bus.key_ready;  end
            ST_DATA: begin out_vld = bus.data_valid; out_rdy = bus.data_ready; end
            default: ;
        endcase
    end

    assign fwd     = (state == ST_SEED) | (state == ST_KEY) | (state == ST_DATA);
    assign done_in = (cnt == len);
    assign out_hs  = out_vld & out_rdy;
    assign last_hs = fwd & done_in & out_hs;
    // The cycle that drains the last beat can already decode the next command.
    assign free    = (state == ST_IDLE) | last_hs;

    // Completion this cycle counts, so KEY immediately followed by DATA is legal.
    assign seeded_eff = seeded | (last_hs & (state == ST_SEED));
    assign keyed_eff  = keyed  | (last_hs & (state == ST_KEY));

    assign dec_bad_op = (bus.cmd_op == OP_RSVD) |
                        ((bus.cmd_op == OP_KEY) & (bus.cmd_key_size == KS_ILLEGAL));
    assign dec_order  = (bus.cmd_op == OP_DATA) & ~(seeded_eff & keyed_eff);

    always_comb begin
        cmd_ready = 1'b0;
        if (rst)
            cmd_ready = 1'b0;
        else if (free || state == ST_DROP)
            cmd_ready = 1'b1;
        else if (!done_in)
            cmd_ready = ~out_vld | out_rdy;
    end

    assign bus.cmd_ready = cmd_ready;
    assign acc           = bus.cmd_valid & cmd_ready;
    assign blk_inc       = last_hs & (state == ST_DATA);

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        len_n         = len;
        ks_n          = ks_q;
        seed_load     = 1'b0;
        key_load      = 1'b0;
        data_load     = 1'b0;
        set_err_op    = 1'b0;
        set_err_order = 1'b0;
        if (last_hs)
            state_n = ST_IDLE;
        if (acc) begin
            if (free) begin
                cnt_n = 4'd1;
                if (dec_bad_op) begin
                    set_err_op = 1'b1;
                    state_n    = ST_IDLE;
                end else begin
                    case (bus.cmd_op)
                        OP_SEED: begin
                            state_n   = ST_SEED;
                            len_n     = 4'd1;
                            seed_load = 1'b1;
                        end
                        OP_KEY: begin
                            state_n  = ST_KEY;
                            len_n    = key_beats(bus.cmd_key_size);
                            ks_n     = bus.cmd_key_size;
                            key_load = 1'b1;
                        end
                        default: begin
                            len_n = DATA_BEATS;
                            if (dec_order) begin
                                state_n       = ST_DROP;
                                set_err_order = 1'b1;
                            end else begin
                                state_n   = ST_DATA;
                                data_load = 1'b1;
                            end
                        end
                    endcase
                end
            end else begin
                cnt_n = cnt + 4'd1;
                case (state)
                    ST_SEED: seed_load = 1'b1;
                    ST_KEY:  key_load  = 1'b1;
                    ST_DATA: data_load = 1'b1;
                    ST_DROP: if (cnt_n == len) state_n = ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            len         <= '0;
            ks_q        <= '0;
            seeded      <= 1'b0;
            keyed       <= 1'b0;
            err_op_q    <= 1'b0;
            err_order_q <= 1'b0;
            blk_count_q <= '0;
        end else begin
            cnt         <= cnt_n;
            len         <= len_n;
            ks_q        <= ks_n;
            seeded      <= seeded_eff;
            keyed       <= keyed_eff;
            err_op_q    <= set_err_op | (err_op_q & ~bus.err_clear);
            err_order_q <= set_err_order | (err_order_q & ~bus.err_clear);
            blk_count_q <= blk_count_q + 16'(blk_inc);
        end
    end

    assign bus.key_size  = ks_q;
    assign bus.err_op    = err_op_q;
    assign bus.err_order = err_order_q;
    assign bus.blk_count = blk_count_q;

    smaesh_seq_obuf #(.W(SEED_W)) u_seed_buf (
        .clk(clk), .rst(rst), .load(seed_load), .payload(bus.cmd_seed),
        .valid(bus.seed_valid), .ready(bus.seed_ready), .q(bus.seed)
    );

    smaesh_seq_obuf #(.W(WW)) u_key_buf (
        .clk(clk), .rst(rst), .load(key_load), .payload(bus.cmd_word),
        .valid(bus.key_valid), .ready(bus.key_ready), .q(bus.key_word)
    );

    smaesh_seq_obuf #(.W(WW)) u_data_buf (
        .clk(clk), .rst(rst), .load(data_load), .payload(bus.cmd_word),
        .valid(bus.data_valid), .ready(bus.data_ready), .q(bus.data_word)
    );

endmodule
